weight_preload_engine: RTL and testbench
========================================

// Module: weight_preload_engine
// PURPOSE
//  Parametrised preload engine for an ROWS x COLS weight-stationary systolic array.
//  Accepts a column-major weight stream over a valid/ready handshake and splits each weight into:
//    - a reduced MSB part, written to the weight memory;
//    - a nonzero LSB compensation part, written with its row index to the per-column compensation memory.
//  Generates all write addresses, counts compensation entries per column, and flags column/load completion.
// PARAMETERS
//  ROWS      8  array rows (weights per column)
//  COLS      8  array columns
//  WEIGHT_W  8  input weight width
//  COMP_W    3  LSB compensation width; RED_W = WEIGHT_W-COMP_W (derived)
//  MAX_COMP  8  compensation slots per column (1..ROWS)
// PORTS
//  clk            in   1               clock
//  rst            in   1               asynchronous, active-high reset
//  start          in   1               begin a load (honoured in IDLE only)
//  in_valid       in   1               weight beat valid
//  in_ready       out  1               engine accepts beat
//  in_weight      in   WEIGHT_W        weight, column-major order (row 0..ROWS-1 of col 0 first)
//  wmem_we        out  1               weight memory write strobe
//  wmem_addr      out  clog2(ROWS*COLS) col*ROWS+row
//  wmem_data      out  RED_W           in_weight[WEIGHT_W-1:COMP_W]
//  cmem_we        out  1               compensation memory write strobe
//  cmem_addr      out  clog2(COLS*MAX_COMP) col*MAX_COMP+slot
//  cmem_data      out  COMP_W          in_weight[COMP_W-1:0]
//  cmem_row       out  clog2(ROWS)     row index of the compensated weight
//  col_done       out  1               1-cycle pulse: final write of a column
//  col_comp_cnt   out  clog2(MAX_COMP+1) entries stored for that column (valid with col_done)
//  load_done      out  1               1-cycle pulse: final write of the whole load
//  comp_overflow  out  1               sticky: a compensation entry was dropped
// BEHAVIOUR
//  - Reset: FSM=IDLE, counters=0, all outputs 0.
//    Reset mid-load abandons the load; no further writes are issued.
//  - FSM IDLE -> LOAD on start.
//    Entry into LOAD clears the row/col/slot counters and comp_overflow.
//    start is ignored while in LOAD.
//  - in_ready = (state==LOAD). A beat transfers when in_valid&&in_ready; no backpressure otherwise.
//  - Latency: beat accepted at cycle t gives the registered write outputs at t+1.
//    wmem_we fires for every beat.
//  - cmem_we fires at t+1 only when LSBs != 0 and slot < MAX_COMP; slot then increments.
//    When LSBs != 0 and slot == MAX_COMP: no write, comp_overflow set. The weight write still occurs.
//  - Row wraps at ROWS-1 to 0, advances col and clears slot.
//    col_done pulses with the write of row ROWS-1.
//    col_comp_cnt includes that beat's own entry, if it was stored.
//  - Last beat (row ROWS-1, col COLS-1): load_done pulses at t+1, together with col_done.
//    FSM returns to IDLE at t+1, so in_ready is 0 from t+1.
//  - start and in_valid both high in IDLE: no beat accepted that cycle.
//  - Zero weight: wmem write of 0, no cmem write.
// CONFIGURATION
//  PRELOAD_STALL_CNT_EN defined:
//    - adds output stall_cnt [15:0], the number of LOAD cycles with in_valid==0.
//    - stall_cnt saturates at 16'hFFFF, is cleared on entry to LOAD, and holds in IDLE.
//  Not defined: no stall_cnt port and no counter logic. All other behaviour is identical.
// STRUCTURE
//  - Package preload_pkg:
//    - state enum {IDLE, LOAD};
//    - clog2-derived width constants (ADDR_W, CADDR_W, ROW_W, CNT_W).
//  - Sub-module preload_addr_gen:
//    - row/col/slot counters, wrap and last-beat detection;
//    - driven by an accept strobe and a comp-store strobe.
//  - Top level holds the FSM, the weight split, and the output register stage.
// TESTING
//  1. Reset, start, 64 weights 8'h08 (LSB=0) -> 64 wmem writes of 5'h01 at addrs 0..63, no cmem_we.
//     col_done x8 with col_comp_cnt=0; load_done on cycle after beat 64.
//  2. Col 2 row 5 = 8'hFB, others 0 -> one cmem write: addr 16, data 3'h3, row 5.
//     col 2 col_done has col_comp_cnt=1.
//  3. MAX_COMP=4, col 0 all 8'h01 -> cmem addrs 0..3 written, 4 drops, comp_overflow=1.
//     col_comp_cnt=4; comp_overflow cleared by next start.
//  4. in_valid toggled randomly, and in_valid high in IDLE -> beats only taken when in_ready.
//     Address sequence unbroken; no beat taken after load_done.
//  5. rst asserted at beat 20, then new start -> writes restart at wmem_addr 0.
//     No writes occur during or after reset before start.
//  6. Compiled with PRELOAD_STALL_CNT_EN, 10 idle cycles inside LOAD -> stall_cnt=10 at load_done.
//     Without the macro, the build has no stall_cnt port.

Source files
------------

// File: rtl/preload_pkg.sv
// Shared types and default-configuration widths for the weight preload engine.
package preload_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_e;

    // Bit width needed to index n items, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_ROWS     = 8;
    localparam int unsigned DEF_COLS     = 8;
    localparam int unsigned DEF_WEIGHT_W = 8;
    localparam int unsigned DEF_COMP_W   = 3;
    localparam int unsigned DEF_MAX_COMP = 8;

    localparam int unsigned ADDR_W  = clog2_min1(DEF_ROWS * DEF_COLS);
    localparam int unsigned CADDR_W = clog2_min1(DEF_COLS * DEF_MAX_COMP);
    localparam int unsigned ROW_W   = clog2_min1(DEF_ROWS);
    localparam int unsigned CNT_W   = clog2_min1(DEF_MAX_COMP + 1);

endpackage

// File: rtl/preload_addr_gen.sv
// Row/column/slot counters for the column-major preload stream.
module preload_addr_gen
    import preload_pkg::*;
#(
    parameter int unsigned ROWS     = DEF_ROWS,
    parameter int unsigned COLS     = DEF_COLS,
    parameter int unsigned ROW_BITS = ROW_W,
    parameter int unsigned COL_BITS = clog2_min1(DEF_COLS),
    parameter int unsigned CNT_BITS = CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                accept_i,
    input  logic                comp_store_i,
    output logic [ROW_BITS-1:0] row_o,
    output logic [COL_BITS-1:0] col_o,
    output logic [CNT_BITS-1:0] slot_o,
    output logic                row_last_c,
    output logic                last_beat_c
);

    logic [ROW_BITS-1:0] row_q, row_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic [CNT_BITS-1:0] slot_q, slot_d;
    logic                col_last_c;

    assign row_last_c  = (row_q == ROW_BITS'(ROWS - 1));
    assign col_last_c  = (col_q == COL_BITS'(COLS - 1));
    assign last_beat_c = row_last_c && col_last_c;

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign slot_o = slot_q;

    // Advance row per accepted beat; a row wrap moves to the next column and frees its slots.
    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        slot_d = slot_q;
        if (clear_i) begin
            row_d  = '0;
            col_d  = '0;
            slot_d = '0;
        end else if (accept_i) begin
            if (row_last_c) begin
                row_d  = '0;
                col_d  = col_last_c ? '0 : col_q + COL_BITS'(1);
                slot_d = '0;
            end else begin
                row_d  = row_q + ROW_BITS'(1);
                slot_d = slot_q + CNT_BITS'(comp_store_i);
            end
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q  <= '0;
            col_q  <= '0;
            slot_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/weight_preload_engine.sv
// Weight preload engine: splits each streamed weight into an MSB part for the
// weight memory and a sparse LSB compensation entry for the per-column memory.
// Optional feature macro: PRELOAD_STALL_CNT_EN adds the stall_cnt output.
module weight_preload_engine
    import preload_pkg::*;
#(
    parameter  int unsigned ROWS       = DEF_ROWS,
    parameter  int unsigned COLS       = DEF_COLS,
    parameter  int unsigned WEIGHT_W   = DEF_WEIGHT_W,
    parameter  int unsigned COMP_W     = DEF_COMP_W,
    parameter  int unsigned MAX_COMP   = DEF_MAX_COMP,
    localparam int unsigned RED_W      = WEIGHT_W - COMP_W,
    localparam int unsigned ADDR_BITS  = clog2_min1(ROWS * COLS),
    localparam int unsigned CADDR_BITS = clog2_min1(COLS * MAX_COMP),
    localparam int unsigned ROW_BITS   = clog2_min1(ROWS),
    localparam int unsigned COL_BITS   = clog2_min1(COLS),
    localparam int unsigned CNT_BITS   = clog2_min1(MAX_COMP + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WEIGHT_W-1:0]   in_weight,
    output logic                  wmem_we,
    output logic [ADDR_BITS-1:0]  wmem_addr,
    output logic [RED_W-1:0]      wmem_data,
    output logic                  cmem_we,
    output logic [CADDR_BITS-1:0] cmem_addr,
    output logic [COMP_W-1:0]     cmem_data,
    output logic [ROW_BITS-1:0]   cmem_row,
    output logic                  col_done,
    output logic [CNT_BITS-1:0]   col_comp_cnt,
    output logic                  load_done,
    output logic                  comp_overflow
`ifdef PRELOAD_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    state_e              state_q;
    logic                accept_c;
    logic                clear_c;
    logic                lsb_nz_c;
    logic                slot_full_c;
    logic                comp_store_c;
    logic                comp_drop_c;
    logic [ROW_BITS-1:0] row;
    logic [COL_BITS-1:0] col;
    logic [CNT_BITS-1:0] slot;
    logic                row_last_c;
    logic                last_beat_c;

    assign accept_c     = in_valid && in_ready;
    assign clear_c      = (state_q == IDLE) && start;
    assign lsb_nz_c     = (in_weight[COMP_W-1:0] != '0);
    assign slot_full_c  = (slot == CNT_BITS'(MAX_COMP));
    assign comp_store_c = accept_c && lsb_nz_c && !slot_full_c;
    assign comp_drop_c  = accept_c && lsb_nz_c && slot_full_c;

    preload_addr_gen #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .ROW_BITS (ROW_BITS),
        .COL_BITS (COL_BITS),
        .CNT_BITS (CNT_BITS)
    ) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear_c),
        .accept_i     (accept_c),
        .comp_store_i (comp_store_c),
        .row_o        (row),
        .col_o        (col),
        .slot_o       (slot),
        .row_last_c   (row_last_c),
        .last_beat_c  (last_beat_c)
    );

    // Load FSM; in_ready is registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            in_ready <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= LOAD;
                        in_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept_c && last_beat_c) begin
                        state_q  <= IDLE;
                        in_ready <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

    // Write-port register stage: one cycle after the accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wmem_we       <= 1'b0;
            wmem_addr     <= '0;
            wmem_data     <= '0;
            cmem_we       <= 1'b0;
            cmem_addr     <= '0;
            cmem_data     <= '0;
            cmem_row      <= '0;
            col_done      <= 1'b0;
            col_comp_cnt  <= '0;
            load_done     <= 1'b0;
            comp_overflow <= 1'b0;
        end else begin
            wmem_we   <= accept_c;
            cmem_we   <= comp_store_c;
            col_done  <= accept_c && row_last_c;
            load_done <= accept_c && last_beat_c;
            if (accept_c) begin
                wmem_addr <= ADDR_BITS'(col) * ADDR_BITS'(ROWS) + ADDR_BITS'(row);
                wmem_data <= in_weight[WEIGHT_W-1:COMP_W];
            end
            if (comp_store_c) begin
                cmem_addr <= CADDR_BITS'(col) * CADDR_BITS'(MAX_COMP) + CADDR_BITS'(slot);
                cmem_data <= in_weight[COMP_W-1:0];
                cmem_row  <= row;
            end
            if (accept_c && row_last_c) begin
                col_comp_cnt <= slot + CNT_BITS'(comp_store_c);
            end
            if (clear_c) begin
                comp_overflow <= 1'b0;
            end else if (comp_drop_c) begin
                comp_overflow <= 1'b1;
            end
        end
    end

`ifdef PRELOAD_STALL_CNT_EN
    // Saturating count of LOAD cycles without a valid beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (clear_c) begin
            stall_cnt <= '0;
        end else if ((state_q == LOAD) && !in_valid && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_weight_preload_engine.sv
// Self-checking bench for weight_preload_engine: one default instance and one
// with MAX_COMP=4 share the stimulus; each is compared against its own model.
module tb_weight_preload_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_weight;

    logic       in_ready0, wmem_we0, cmem_we0, col_done0, load_done0, comp_overflow0;
    logic [5:0] wmem_addr0;
    logic [4:0] wmem_data0;
    logic [5:0] cmem_addr0;
    logic [2:0] cmem_data0, cmem_row0;
    logic [3:0] col_comp_cnt0;

    logic       in_ready1, wmem_we1, cmem_we1, col_done1, load_done1, comp_overflow1;
    logic [5:0] wmem_addr1;
    logic [4:0] wmem_data1;
    logic [4:0] cmem_addr1;
    logic [2:0] cmem_data1, cmem_row1;
    logic [2:0] col_comp_cnt1;
`ifdef PRELOAD_STALL_CNT_EN
    logic [15:0] stall0, stall1;
`endif

    always #5 clk = ~clk;

    weight_preload_engine dut0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready0),
        .in_weight(in_weight), .wmem_we(wmem_we0), .wmem_addr(wmem_addr0),
        .wmem_data(wmem_data0), .cmem_we(cmem_we0), .cmem_addr(cmem_addr0),
        .cmem_data(cmem_data0), .cmem_row(cmem_row0), .col_done(col_done0),
        .col_comp_cnt(col_comp_cnt0), .load_done(load_done0), .comp_overflow(comp_overflow0)
`ifdef PRELOAD_STALL_CNT_EN
        , .stall_cnt(stall0)
`endif
    );

    weight_preload_engine #(.MAX_COMP(4)) dut1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
        .in_weight(in_weight), .wmem_we(wmem_we1), .wmem_addr(wmem_addr1),
        .wmem_data(wmem_data1), .cmem_we(cmem_we1), .cmem_addr(cmem_addr1),
        .cmem_data(cmem_data1), .cmem_row(cmem_row1), .col_done(col_done1),
        .col_comp_cnt(col_comp_cnt1), .load_done(load_done1), .comp_overflow(comp_overflow1)
`ifdef PRELOAD_STALL_CNT_EN
        , .stall_cnt(stall1)
`endif
    );

    typedef struct {
        int rdy; int we; int waddr; int wdata;
        int cwe; int caddr; int cdata; int crow;
        int cdone; int ccnt; int ldone; int ovf;
    } obs_t;

    typedef struct {
        logic [7:0] w;
        int         wdata;
        int         cwe;
        int         cdata;
        int         caddr;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Reference model state: one stream position, per-instance compensation state.
    bit m_load;
    int m_n;
    int m_cnt[2][8];
    bit m_ovf[2];
    int m_stall;

    int tw, tcd, tld;

    function automatic int mc_of(input int d);
        return (d == 0) ? 8 : 4;
    endfunction

    function automatic obs_t get_obs(input int d);
        obs_t o;
        if (d == 0) begin
            o.rdy = int'(in_ready0);   o.we = int'(wmem_we0);
            o.waddr = int'(wmem_addr0); o.wdata = int'(wmem_data0);
            o.cwe = int'(cmem_we0);    o.caddr = int'(cmem_addr0);
            o.cdata = int'(cmem_data0); o.crow = int'(cmem_row0);
            o.cdone = int'(col_done0); o.ccnt = int'(col_comp_cnt0);
            o.ldone = int'(load_done0); o.ovf = int'(comp_overflow0);
        end else begin
            o.rdy = int'(in_ready1);   o.we = int'(wmem_we1);
            o.waddr = int'(wmem_addr1); o.wdata = int'(wmem_data1);
            o.cwe = int'(cmem_we1);    o.caddr = int'(cmem_addr1);
            o.cdata = int'(cmem_data1); o.crow = int'(cmem_row1);
            o.cdone = int'(col_done1); o.ccnt = int'(col_comp_cnt1);
            o.ldone = int'(load_done1); o.ovf = int'(comp_overflow1);
        end
        return o;
    endfunction

    task automatic chk(input string nm, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d @%0t: got %0d expected %0d", nm, d, $time, act, exp);
        end
    endtask

    // Apply one cycle of inputs, predict from the model, then compare after the edge.
    task automatic step(input bit s, input bit v, input logic [7:0] w);
        obs_t e[2];
        obs_t o;
        bit   acc;
        int   row, col, lsb, wi, mc;
        start     = s;
        in_valid  = v;
        in_weight = w;
        acc = m_load && v;
        wi  = int'(w);
        lsb = wi & 7;
        row = m_n % 8;
        col = m_n / 8;
        for (int d = 0; d < 2; d++) begin
            e[d] = '{default: 0};
            mc   = mc_of(d);
            if (acc) begin
                e[d].we    = 1;
                e[d].waddr = m_n;
                e[d].wdata = wi >> 3;
                if (lsb != 0) begin
                    if (m_cnt[d][col] < mc) begin
                        e[d].cwe   = 1;
                        e[d].caddr = col * mc + m_cnt[d][col];
                        e[d].cdata = lsb;
                        e[d].crow  = row;
                        m_cnt[d][col]++;
                    end else begin
                        m_ovf[d] = 1'b1;
                    end
                end
                if (row == 7) begin
                    e[d].cdone = 1;
                    e[d].ccnt  = m_cnt[d][col];
                    e[d].ldone = (m_n == 63) ? 1 : 0;
                end
            end else if (!m_load && s) begin
                m_ovf[d] = 1'b0;
                for (int c = 0; c < 8; c++) m_cnt[d][c] = 0;
            end
            e[d].ovf = int'(m_ovf[d]);
        end
        if (acc) begin
            m_n++;
            if (m_n == 64) m_load = 1'b0;
        end else if (!m_load && s) begin
            m_load  = 1'b1;
            m_n     = 0;
            m_stall = 0;
        end else if (m_load && !v) begin
            m_stall++;
        end
        e[0].rdy = int'(m_load);
        e[1].rdy = int'(m_load);

        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            o = get_obs(d);
            chk("in_ready", d, o.rdy, e[d].rdy);
            chk("wmem_we", d, o.we, e[d].we);
            if (e[d].we != 0) begin
                chk("wmem_addr", d, o.waddr, e[d].waddr);
                chk("wmem_data", d, o.wdata, e[d].wdata);
            end
            chk("cmem_we", d, o.cwe, e[d].cwe);
            if (e[d].cwe != 0) begin
                chk("cmem_addr", d, o.caddr, e[d].caddr);
                chk("cmem_data", d, o.cdata, e[d].cdata);
                chk("cmem_row", d, o.crow, e[d].crow);
            end
            chk("col_done", d, o.cdone, e[d].cdone);
            if (e[d].cdone != 0) chk("col_comp_cnt", d, o.ccnt, e[d].ccnt);
            chk("load_done", d, o.ldone, e[d].ldone);
            chk("comp_overflow", d, o.ovf, e[d].ovf);
        end
`ifdef PRELOAD_STALL_CNT_EN
        if (e[0].ldone != 0) begin
            chk("stall_cnt", 0, int'(stall0), m_stall);
            chk("stall_cnt", 1, int'(stall1), m_stall);
        end
`endif
        tw  += int'(wmem_we0);
        tcd += int'(col_done0);
        tld += int'(load_done0);
    endtask

    // Asynchronous reset; outputs must drop without waiting for a clock edge.
    task automatic do_reset();
        obs_t o;
        start    = 1'b0;
        in_valid = 1'b0;
        rst      = 1'b1;
        m_load   = 1'b0;
        m_n      = 0;
        m_ovf[0] = 1'b0;
        m_ovf[1] = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            o = get_obs(d);
            chk("rst_in_ready", d, o.rdy, 0);
            chk("rst_wmem_we", d, o.we, 0);
            chk("rst_cmem_we", d, o.cwe, 0);
            chk("rst_col_done", d, o.cdone, 0);
            chk("rst_load_done", d, o.ldone, 0);
            chk("rst_overflow", d, o.ovf, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [7:0] gen(input int mode, input int n);
        case (mode)
            0:       return 8'h08;
            1:       return (n == 2 * 8 + 5) ? 8'hFB : 8'h00;
            2:       return (n < 8) ? 8'h01 : 8'h00;
            3:       return 8'($urandom);
            default: return 8'h00;
        endcase
    endfunction

    // Stream the rest of a load; pct<0 inserts exactly 10 idle cycles before beat 10.
    task automatic body(input int mode, input int pct, input int abort_at);
        int guard = 0;
        int gap   = 0;
        bit v, s;
        while (m_load && guard < 5000) begin
            guard++;
            if (abort_at >= 0 && m_n == abort_at) begin
                do_reset();
                return;
            end
            if (pct < 0) begin
                v = !(m_n == 10 && gap < 10);
                if (!v) gap++;
            end else if (pct >= 100) begin
                v = 1'b1;
            end else begin
                v = ($urandom_range(0, 99) < pct);
            end
            s = (mode == 3) && ($urandom_range(0, 7) == 0);
            step(s, v, gen(mode, m_n));
        end
        if (m_load) chk("load_timeout", 0, guard, 0);
        repeat (3) step(1'b0, 1'b1, 8'($urandom));
    endtask

    task automatic run_load(input int mode, input int pct, input int abort_at);
        tw = 0; tcd = 0; tld = 0;
        step(1'b1, mode == 3, 8'hFF);
        body(mode, pct, abort_at);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[8];
        obs_t o;
        tbl[0] = '{8'h00, 0,  0, 0, 0};
        tbl[1] = '{8'hFB, 31, 1, 3, 0};
        tbl[2] = '{8'h08, 1,  0, 0, 0};
        tbl[3] = '{8'h07, 0,  1, 7, 1};
        tbl[4] = '{8'hFF, 31, 1, 7, 2};
        tbl[5] = '{8'h01, 0,  1, 1, 3};
        tbl[6] = '{8'hF8, 31, 0, 0, 0};
        tbl[7] = '{8'h80, 16, 0, 0, 0};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_weight = 8'h00;
        m_load = 1'b0; m_n = 0; m_stall = 0;
        m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
        for (int d = 0; d < 2; d++) for (int c = 0; c < 8; c++) m_cnt[d][c] = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            o = get_obs(d);
            chk("reset_in_ready", d, o.rdy, 0);
            chk("reset_wmem_we", d, o.we, 0);
            chk("reset_wmem_addr", d, o.waddr, 0);
            chk("reset_cmem_we", d, o.cwe, 0);
            chk("reset_load_done", d, o.ldone, 0);
            chk("reset_overflow", d, o.ovf, 0);
        end
        rst = 1'b0;
        step(1'b0, 1'b1, 8'h11);

        // Column 0 from a table of split cases.
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, tbl[i].w);
            o = get_obs(0);
            chk("tbl_wmem_we", i, o.we, 1);
            chk("tbl_wmem_data", i, o.wdata, tbl[i].wdata);
            chk("tbl_cmem_we", i, o.cwe, tbl[i].cwe);
            if (tbl[i].cwe != 0) begin
                chk("tbl_cmem_data", i, o.cdata, tbl[i].cdata);
                chk("tbl_cmem_addr", i, o.caddr, tbl[i].caddr);
            end
        end
        o = get_obs(0);
        chk("tbl_col_done", 0, o.cdone, 1);
        chk("tbl_col_comp_cnt", 0, o.ccnt, 4);
        o = get_obs(1);
        chk("tbl_col_comp_cnt", 1, o.ccnt, 4);
        chk("tbl_no_overflow", 1, o.ovf, 0);
        body(4, 100, -1);

        // Uniform weights with zero LSBs.
        run_load(0, 100, -1);
        chk("t1_wmem_writes", 0, tw, 64);
        chk("t1_col_done_cnt", 0, tcd, 8);
        chk("t1_load_done_cnt", 0, tld, 1);

        // Single compensated weight.
        run_load(1, 100, -1);

        // Column overflow on the MAX_COMP=4 instance, cleared by the next start.
        run_load(2, 100, -1);
        chk("t3_overflow", 1, int'(comp_overflow1), 1);
        chk("t3_overflow", 0, int'(comp_overflow0), 0);
        step(1'b1, 1'b0, 8'h00);
        chk("t3_overflow_cleared", 1, int'(comp_overflow1), 0);
        body(3, 100, -1);

        // Random valid gaps and random weights.
        repeat (4) run_load(3, 60, -1);

        // Reset in the middle of a load, then restart.
        run_load(0, 100, 20);
        repeat (4) step(1'b0, 1'b1, 8'h55);
        run_load(0, 100, -1);
        chk("t5_wmem_writes", 0, tw, 64);

        // Exactly ten idle cycles inside a load.
        run_load(3, -1, -1);
`ifdef PRELOAD_STALL_CNT_EN
        chk("t6_stall_cnt", 0, int'(stall0), 10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
